// File: rtl/alu_operand_sequencer_pkg.sv
// Shared ALU definitions for the operand sequencer.
//   state_e   : sequencer FSM states (2-bit, 00/01/10; 11 is illegal)
//   ALU_WIDTH : operand width of the ALU bitwise units (XOR unit width)
package alu_operand_sequencer_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    LOAD_X = 2'b00,
    LOAD_Y = 2'b01,
    HOLD   = 2'b10
  } state_e;

endpackage

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the ALU bitwise units.
// Collects an X then a Y operand over one shared bus in two beats. It holds the
// pair on x_out/y_out until consumed and counts consumed pairs.
//
// Handshake: a beat is accepted on a rising edge with in_valid && in_ready.
// A pair is consumed on a rising edge with out_valid && out_ready. Neither
// valid may depend on the matching ready. in_data is sampled only on accept.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : operand beats (X first, then Y)
//   clr                 : synchronous abort of a partially loaded pair
//   x_out/y_out         : held operand pair; bit i feeds the unit's x_i/y_i
//   out_valid/out_ready : pair handshake toward the bitwise units
//   pair_count          : consumed-pair count, wraps modulo 2^CNT_W
//   state_o             : current FSM state (debug)
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_count,
  output logic [1:0]       state_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_X;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD_X: begin
        in_ready = !clr;
        if (in_valid && !clr) begin
          x_d     = in_data;
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        in_ready = !clr;
        if (clr) begin
          // Pending X is simply abandoned; it is overwritten by the next X.
          state_d = LOAD_X;
        end else if (in_valid) begin
          y_d     = in_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // A new X may enter on the same edge the pair leaves; clr only
        // blocks that beat and never drops the held pair.
        in_ready  = out_ready && !clr;
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (in_valid && !clr) begin
            x_d     = in_data;
            state_d = LOAD_Y;
          end else begin
            state_d = LOAD_X;
          end
        end
      end
      default: state_d = LOAD_X;  // illegal encoding 11 recovers
    endcase
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign pair_count = cnt_q;
  assign state_o    = state_q;

endmodule
